// File: rtl/chroma_lut_if.sv
// Register-port and pixel-lookup signal bundle for chroma_lut.
// The master side is the host/video driver; the slave side is the colour table.
interface chroma_lut_if #(
    parameter int unsigned NUM_COLORS  = 16,
    parameter int unsigned LUMA_WIDTH  = 6,
    parameter int unsigned AMP_WIDTH   = 3,
    parameter int unsigned PHASE_WIDTH = 8
);
    localparam int unsigned IDXW  = $clog2(NUM_COLORS);
    localparam int unsigned ADDRW = IDXW + 2;
    localparam int unsigned DATW  = 8;

    logic                   busy;
    logic                   wr_en;
    logic [ADDRW-1:0]       wr_addr;
    logic [DATW-1:0]        wr_data;
    logic                   wr_ack;
    logic                   rd_en;
    logic [ADDRW-1:0]       rd_addr;
    logic [DATW-1:0]        rd_data;
    logic                   rd_valid;
    logic                   pix_valid;
    logic [IDXW-1:0]        index;
    logic                   oddline;
    logic                   pal_mode;
    logic [LUMA_WIDTH-1:0]  luma;
    logic [AMP_WIDTH-1:0]   amplitude;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   out_valid;

    modport master (
        input  busy, wr_ack, rd_data, rd_valid, luma, amplitude, phase, out_valid,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, pix_valid, index, oddline, pal_mode
    );

    modport slave (
        output busy, wr_ack, rd_data, rd_valid, luma, amplitude, phase, out_valid,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, pix_valid, index, oddline, pal_mode
    );
endinterface

// File: rtl/chroma_lut.sv
// Run-time programmable luma/amplitude/phase colour table: default load after reset,
// byte-wide register access, and a 2-stage pixel lookup with PAL phase alternation.
module chroma_lut #(
    parameter int unsigned NUM_COLORS  = 16,
    parameter int unsigned LUMA_WIDTH  = 6,
    parameter int unsigned AMP_WIDTH   = 3,
    parameter int unsigned PHASE_WIDTH = 8
) (
    input  logic         clk_dot4x,
    input  logic         rst,
    chroma_lut_if.slave  bus
);
    localparam int unsigned IDXW      = $clog2(NUM_COLORS);
    localparam int unsigned DATW      = 8;
    localparam int unsigned DFLT_N    = 16;
    localparam int unsigned DFLT_IDXW = 4;

    localparam logic [1:0]      FLD_LUMA  = 2'd0;
    localparam logic [1:0]      FLD_PHASE = 2'd1;
    localparam logic [1:0]      FLD_AMP   = 2'd2;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_COLORS - 1);

    localparam logic [7:0] DFLT_LUMA [DFLT_N] = '{
        8'd19, 8'd59, 8'd31, 8'd44, 8'd34, 8'd39, 8'd28, 8'd50,
        8'd34, 8'd28, 8'd39, 8'd31, 8'd38, 8'd50, 8'd38, 8'd44
    };
    localparam logic [7:0] DFLT_PHASE [DFLT_N] = '{
        8'd0,  8'd0,   8'd80, 8'd208, 8'd32, 8'd160, 8'd0, 8'd128,
        8'd96, 8'd112, 8'd80, 8'd0,   8'd0,  8'd160, 8'd0, 8'd0
    };
    localparam logic [7:0] DFLT_AMP [DFLT_N] = '{
        8'd7, 8'd7, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd0,
        8'd0, 8'd2, 8'd2, 8'd7, 8'd7, 8'd2, 8'd2, 8'd7
    };

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q;
    logic [IDXW-1:0] init_cnt_q;
    logic            busy_q;

    logic [LUMA_WIDTH-1:0]  luma_tbl_q  [NUM_COLORS];
    logic [PHASE_WIDTH-1:0] phase_tbl_q [NUM_COLORS];
    logic [AMP_WIDTH-1:0]   amp_tbl_q   [NUM_COLORS];

    logic            wr_ack_q;
    logic            rd_valid_q;
    logic [DATW-1:0] rd_data_q;
    logic [DATW-1:0] rd_data_d;

    logic                   s1_valid_q;
    logic [LUMA_WIDTH-1:0]  s1_luma_q;
    logic [PHASE_WIDTH-1:0] s1_phase_q;
    logic [AMP_WIDTH-1:0]   s1_amp_q;
    logic                   s1_odd_q;
    logic                   s1_pal_q;

    logic                   out_valid_q;
    logic [LUMA_WIDTH-1:0]  out_luma_q;
    logic [AMP_WIDTH-1:0]   out_amp_q;
    logic [PHASE_WIDTH-1:0] out_phase_q;
    logic [PHASE_WIDTH-1:0] out_phase_d;

    logic                 run;
    logic [IDXW-1:0]      wr_idx;
    logic [1:0]           wr_fld;
    logic [IDXW-1:0]      rd_idx;
    logic [1:0]           rd_fld;
    logic [DFLT_IDXW-1:0] dflt_idx;
    logic                 dflt_hit;

    // Address decode and default-table selection for the entry being initialised.
    always_comb begin
        run      = (state_q == ST_RUN);
        wr_idx   = bus.wr_addr[IDXW+1:2];
        wr_fld   = bus.wr_addr[1:0];
        rd_idx   = bus.rd_addr[IDXW+1:2];
        rd_fld   = bus.rd_addr[1:0];
        dflt_idx = DFLT_IDXW'(init_cnt_q);
        dflt_hit = (32'(init_cnt_q) < DFLT_N);
    end

    // Init sequencer: one entry per cycle, then run until the next reset.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + IDXW'(1);
                    if (init_cnt_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q    <= ST_INIT;
                    init_cnt_q <= '0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    // Table storage: default load during init, register-port writes afterwards.
    always_ff @(posedge clk_dot4x) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                luma_tbl_q[init_cnt_q]  <= dflt_hit ? LUMA_WIDTH'(DFLT_LUMA[dflt_idx])   : '0;
                phase_tbl_q[init_cnt_q] <= dflt_hit ? PHASE_WIDTH'(DFLT_PHASE[dflt_idx]) : '0;
                amp_tbl_q[init_cnt_q]   <= dflt_hit ? AMP_WIDTH'(DFLT_AMP[dflt_idx])     : '0;
            end else if (bus.wr_en) begin
                case (wr_fld)
                    FLD_LUMA:  luma_tbl_q[wr_idx]  <= LUMA_WIDTH'(bus.wr_data);
                    FLD_PHASE: phase_tbl_q[wr_idx] <= PHASE_WIDTH'(bus.wr_data);
                    FLD_AMP:   amp_tbl_q[wr_idx]   <= AMP_WIDTH'(bus.wr_data);
                    default:   ;
                endcase
            end
        end
    end

    // Readback mux; the reserved field reads as zero.
    always_comb begin
        rd_data_d = '0;
        case (rd_fld)
            FLD_LUMA:  rd_data_d = DATW'(luma_tbl_q[rd_idx]);
            FLD_PHASE: rd_data_d = DATW'(phase_tbl_q[rd_idx]);
            FLD_AMP:   rd_data_d = DATW'(amp_tbl_q[rd_idx]);
            default:   rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ack_q   <= run && bus.wr_en;
            rd_valid_q <= run && bus.rd_en;
            if (run && bus.rd_en) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    // Lookup stage 1: capture the addressed entry and line controls.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_luma_q  <= '0;
            s1_phase_q <= '0;
            s1_amp_q   <= '0;
            s1_odd_q   <= 1'b0;
            s1_pal_q   <= 1'b0;
        end else begin
            s1_valid_q <= run && bus.pix_valid;
            if (run && bus.pix_valid) begin
                s1_luma_q  <= luma_tbl_q[bus.index];
                s1_phase_q <= phase_tbl_q[bus.index];
                s1_amp_q   <= amp_tbl_q[bus.index];
                s1_odd_q   <= bus.oddline;
                s1_pal_q   <= bus.pal_mode;
            end
        end
    end

    // Unmodulated entries carry no phase; PAL odd lines use the negated angle.
    always_comb begin
        out_phase_d = s1_phase_q;
        if (s1_amp_q == {AMP_WIDTH{1'b1}}) begin
            out_phase_d = '0;
        end else if (s1_pal_q && s1_odd_q) begin
            out_phase_d = {PHASE_WIDTH{1'b0}} - s1_phase_q;
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_luma_q  <= '0;
            out_amp_q   <= '0;
            out_phase_q <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_luma_q  <= s1_luma_q;
                out_amp_q   <= s1_amp_q;
                out_phase_q <= out_phase_d;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.luma      = out_luma_q;
    assign bus.amplitude = out_amp_q;
    assign bus.phase     = out_phase_q;

endmodule

// File: tb/tb_chroma_lut.sv
// Scoreboard bench for chroma_lut: a 16-entry instance for directed register/lookup
// vectors and a 32-entry instance for the zero-filled upper table and streaming lookups.
module tb_chroma_lut;
    localparam int unsigned NA = 16;
    localparam int unsigned NB = 32;

    localparam int TB_LUMA [16] = '{19, 59, 31, 44, 34, 39, 28, 50, 34, 28, 39, 31, 38, 50, 38, 44};
    localparam int TB_AMP  [16] = '{7, 7, 2, 2, 1, 1, 2, 0, 0, 2, 2, 7, 7, 2, 2, 7};
    // Expected phase on a PAL odd line for each default entry.
    localparam int TB_PH_ODD [16] = '{0, 0, 176, 48, 224, 96, 0, 128, 160, 144, 176, 0, 0, 96, 0, 0};

    typedef struct packed {
        logic [5:0] luma;
        logic [2:0] amp;
        logic [7:0] phase;
    } pix_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic mon_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    pix_t       qa_pix[$];
    pix_t       qb_pix[$];
    logic [7:0] qa_rd[$];
    logic [7:0] qb_rd[$];
    int         qa_ack = 0;
    int         run_b = 0;
    int         max_run_b = 0;

    always #5 clk = ~clk;

    chroma_lut_if #(.NUM_COLORS(NA)) bus_a ();
    chroma_lut_if #(.NUM_COLORS(NB)) bus_b ();

    chroma_lut #(.NUM_COLORS(NA), .LUMA_WIDTH(6), .AMP_WIDTH(3), .PHASE_WIDTH(8)) u_dut_a (
        .clk_dot4x (clk),
        .rst       (rst_a),
        .bus       (bus_a.slave)
    );

    chroma_lut #(.NUM_COLORS(NB), .LUMA_WIDTH(6), .AMP_WIDTH(3), .PHASE_WIDTH(8)) u_dut_b (
        .clk_dot4x (clk),
        .rst       (rst_b),
        .bus       (bus_b.slave)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input int idx, input int fld, input int exp);
        bus_a.rd_en   = 1'b1;
        bus_a.rd_addr = 6'(idx * 4 + fld);
        qa_rd.push_back(8'(exp));
        tick();
        bus_a.rd_en   = 1'b0;
    endtask

    task automatic wr_a(input int idx, input int fld, input int data);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = 6'(idx * 4 + fld);
        bus_a.wr_data = 8'(data);
        qa_ack++;
        tick();
        check("a_wr_ack_timing", 32'(bus_a.wr_ack), 1);
        bus_a.wr_en   = 1'b0;
    endtask

    task automatic pix_a(input int idx, input int odd, input int pal,
                         input int l, input int a, input int p);
        pix_t e;
        e.luma  = 6'(l);
        e.amp   = 3'(a);
        e.phase = 8'(p);
        bus_a.pix_valid = 1'b1;
        bus_a.index     = 4'(idx);
        bus_a.oddline   = 1'(odd);
        bus_a.pal_mode  = 1'(pal);
        qa_pix.push_back(e);
        tick();
        bus_a.pix_valid = 1'b0;
    endtask

    task automatic rd_b(input int idx, input int fld, input int exp);
        bus_b.rd_en   = 1'b1;
        bus_b.rd_addr = 7'(idx * 4 + fld);
        qb_rd.push_back(8'(exp));
        tick();
        bus_b.rd_en   = 1'b0;
    endtask

    // Monitor for the 16-entry instance.
    always @(negedge clk) begin : mon_a
        pix_t       e;
        logic [7:0] r;
        if (mon_en) begin
            if (bus_a.out_valid) begin
                if (qa_pix.size() == 0) begin
                    check("a_unexpected_out_valid", 1, 0);
                end else begin
                    e = qa_pix.pop_front();
                    check("a_luma", 32'(bus_a.luma), 32'(e.luma));
                    check("a_amplitude", 32'(bus_a.amplitude), 32'(e.amp));
                    check("a_phase", 32'(bus_a.phase), 32'(e.phase));
                end
            end
            if (bus_a.rd_valid) begin
                if (qa_rd.size() == 0) begin
                    check("a_unexpected_rd_valid", 1, 0);
                end else begin
                    r = qa_rd.pop_front();
                    check("a_rd_data", 32'(bus_a.rd_data), 32'(r));
                end
            end
            if (bus_a.wr_ack) begin
                check("a_wr_ack_expected", (qa_ack > 0) ? 1 : 0, 1);
                if (qa_ack > 0) qa_ack--;
            end
        end
    end

    // Monitor for the 32-entry instance, also tracking the longest out_valid run.
    always @(negedge clk) begin : mon_b
        pix_t       e;
        logic [7:0] r;
        if (mon_en) begin
            if (bus_b.out_valid) begin
                run_b++;
                if (run_b > max_run_b) max_run_b = run_b;
                if (qb_pix.size() == 0) begin
                    check("b_unexpected_out_valid", 1, 0);
                end else begin
                    e = qb_pix.pop_front();
                    check("b_luma", 32'(bus_b.luma), 32'(e.luma));
                    check("b_amplitude", 32'(bus_b.amplitude), 32'(e.amp));
                    check("b_phase", 32'(bus_b.phase), 32'(e.phase));
                end
            end else begin
                run_b = 0;
            end
            if (bus_b.rd_valid) begin
                if (qb_rd.size() == 0) begin
                    check("b_unexpected_rd_valid", 1, 0);
                end else begin
                    r = qb_rd.pop_front();
                    check("b_rd_data", 32'(bus_b.rd_data), 32'(r));
                end
            end
            if (bus_b.wr_ack) check("b_unexpected_wr_ack", 1, 0);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   n;
        pix_t e;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.rd_en = 1'b0; bus_a.rd_addr = '0; bus_a.pix_valid = 1'b0;
        bus_a.index = '0;   bus_a.oddline = 1'b0; bus_a.pal_mode = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.rd_en = 1'b0; bus_b.rd_addr = '0; bus_b.pix_valid = 1'b0;
        bus_b.index = '0;   bus_b.oddline = 1'b0; bus_b.pal_mode = 1'b0;

        repeat (3) tick();
        mon_en = 1'b1;
        check("a_reset_busy", 32'(bus_a.busy), 1);
        check("a_reset_wr_ack", 32'(bus_a.wr_ack), 0);
        check("a_reset_rd_valid", 32'(bus_a.rd_valid), 0);
        check("a_reset_out_valid", 32'(bus_a.out_valid), 0);
        check("a_reset_rd_data", 32'(bus_a.rd_data), 0);
        check("a_reset_luma", 32'(bus_a.luma), 0);
        check("a_reset_amplitude", 32'(bus_a.amplitude), 0);
        check("a_reset_phase", 32'(bus_a.phase), 0);

        // Interrupt the default load at entry 9 and restart it.
        rst_a = 1'b0;
        repeat (9) tick();
        check("a_busy_mid_init", 32'(bus_a.busy), 1);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;

        // Host traffic during init must be ignored entirely.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 6'(1 * 4 + 0); bus_a.wr_data = 8'h00;
        bus_a.rd_en = 1'b1; bus_a.rd_addr = 6'(1 * 4 + 0);
        bus_a.pix_valid = 1'b1; bus_a.index = 4'd1;
        n = 0;
        while (bus_a.busy && n < 100) begin
            tick();
            n++;
            if (n == 4) begin
                bus_a.wr_en = 1'b0;
                bus_a.rd_en = 1'b0;
                bus_a.pix_valid = 1'b0;
            end
        end
        check("a_busy_cycles_after_restart", n, 16);

        rd_a(1, 0, 59);
        rd_a(2, 1, 80);
        rd_a(7, 2, 0);
        rd_a(4, 3, 0);
        rd_a(15, 0, 44);
        tick();
        tick();
        check("a_rd_valid_pulse", 32'(bus_a.rd_valid), 0);
        check("a_rd_data_hold", 32'(bus_a.rd_data), 44);

        // PAL alternation and unmodulated entries, back to back.
        pix_a(2, 0, 1, 31, 2, 80);
        pix_a(2, 1, 1, 31, 2, 176);
        pix_a(0, 0, 1, 19, 7, 0);
        pix_a(0, 1, 1, 19, 7, 0);
        repeat (3) tick();
        check("a_out_valid_idle", 32'(bus_a.out_valid), 0);
        check("a_luma_hold", 32'(bus_a.luma), 19);

        // Write, read and lookup of the same entry in one cycle all see the old value.
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 6'(5 * 4 + 0); bus_a.wr_data = 8'hFF;
        qa_ack++;
        bus_a.rd_en = 1'b1; bus_a.rd_addr = 6'(5 * 4 + 0);
        qa_rd.push_back(8'd39);
        bus_a.pix_valid = 1'b1; bus_a.index = 4'd5; bus_a.oddline = 1'b0; bus_a.pal_mode = 1'b0;
        e.luma = 6'd39; e.amp = 3'd1; e.phase = 8'd160;
        qa_pix.push_back(e);
        tick();
        check("a_wr_ack_same_cycle", 32'(bus_a.wr_ack), 1);
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        pix_a(5, 0, 0, 63, 1, 160);
        rd_a(5, 0, 63);

        wr_a(3, 2, 7);
        wr_a(6, 1, 128);
        wr_a(3, 3, 8'h55);
        wr_a(8, 2, 8'hFA);
        pix_a(3, 1, 1, 44, 7, 0);
        pix_a(4, 1, 0, 34, 1, 32);
        pix_a(6, 1, 1, 28, 2, 128);
        pix_a(9, 1, 1, 28, 2, 144);
        rd_a(3, 1, 208);
        rd_a(3, 3, 0);
        rd_a(3, 2, 7);
        rd_a(8, 2, 2);
        repeat (4) tick();
        check("a_pix_queue_drained", qa_pix.size(), 0);
        check("a_rd_queue_drained", qa_rd.size(), 0);
        check("a_ack_all_seen", qa_ack, 0);

        // 32-entry instance: zero-filled upper half and a full-rate sweep.
        tick();
        rst_b = 1'b0;
        n = 0;
        while (bus_b.busy && n < 200) begin
            tick();
            n++;
        end
        check("b_busy_cycles", n, 32);

        for (int k = 14; k < 32; k++) begin
            rd_b(k, 0, (k < 16) ? TB_LUMA[k] : 0);
        end
        for (int k = 16; k < 32; k++) begin
            rd_b(k, 2, 0);
        end
        rd_b(31, 1, 0);
        repeat (2) tick();

        max_run_b = 0;
        for (int k = 0; k < 32; k++) begin
            bus_b.pix_valid = 1'b1;
            bus_b.index     = 5'(k);
            bus_b.oddline   = 1'b1;
            bus_b.pal_mode  = 1'b1;
            e.luma  = 6'((k < 16) ? TB_LUMA[k] : 0);
            e.amp   = 3'((k < 16) ? TB_AMP[k] : 0);
            e.phase = 8'((k < 16) ? TB_PH_ODD[k] : 0);
            qb_pix.push_back(e);
            tick();
        end
        bus_b.pix_valid = 1'b0;
        repeat (4) tick();
        check("b_out_valid_run", max_run_b, 32);
        check("b_pix_queue_drained", qb_pix.size(), 0);
        check("b_rd_queue_drained", qb_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
